// File: rtl/toaster_seq_ctrl.sv
// Toaster phase sequencer: IDLE -> WARMUP -> TOAST -> COOL_DOWN -> IDLE, phases timed by one shared down-counter.
// Moore outputs decoded from registered state, done/fault flops; no handshake, inputs sampled every rising edge.
module toaster_seq_ctrl #(
    parameter int CNT_W       = 12,
    parameter int WARMUP_MAX  = 100,
    parameter int TOAST_UNIT  = 16,
    parameter int COOL_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cancel,
    input  logic [2:0] darkness,
    input  logic       temp_ok,
    output logic [1:0] state_int,
    output logic       heater_en,
    output logic       lever_lock,
    output logic       done,
    output logic       fault
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WARMUP    = 2'b01,
        TOAST     = 2'b10,
        COOL_DOWN = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] WARM_LD = CNT_W'(WARMUP_MAX - 1);
    localparam logic [CNT_W-1:0] COOL_LD = CNT_W'(COOL_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       dark_q, dark_d;
    logic             fault_q, fault_d;
    logic             done_q, done_d;
    logic             clean_q, clean_d;   // run reached COOL_DOWN through TOAST expiry
    logic [CNT_W-1:0] toast_ld;
    logic [CNT_W-1:0] cnt_dec;
    logic             cnt_zero;

    assign toast_ld = CNT_W'(dark_q) * CNT_W'(TOAST_UNIT) - CNT_W'(1);
    assign cnt_dec  = cnt_q - CNT_W'(1);
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dark_q  <= '0;
            fault_q <= 1'b0;
            done_q  <= 1'b0;
            clean_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dark_q  <= dark_d;
            fault_q <= fault_d;
            done_q  <= done_d;
            clean_q <= clean_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dark_d  = dark_q;
        fault_d = fault_q;
        done_d  = 1'b0;
        clean_d = clean_q;
        unique case (state_q)
            IDLE: begin
                if (start && darkness != 3'd0) begin
                    state_d = WARMUP;
                    cnt_d   = WARM_LD;
                    dark_d  = darkness;
                    fault_d = 1'b0;
                    clean_d = 1'b0;
                end
            end
            WARMUP: begin
                if (cancel) begin
                    state_d = COOL_DOWN;
                    cnt_d   = COOL_LD;
                end else if (temp_ok) begin
                    state_d = TOAST;
                    cnt_d   = toast_ld;
                end else if (cnt_zero) begin
                    state_d = COOL_DOWN;
                    cnt_d   = COOL_LD;
                    fault_d = 1'b1;
                end else begin
                    cnt_d   = cnt_dec;
                end
            end
            TOAST: begin
                if (cancel) begin
                    state_d = COOL_DOWN;
                    cnt_d   = COOL_LD;
                end else if (cnt_zero) begin
                    state_d = COOL_DOWN;
                    cnt_d   = COOL_LD;
                    clean_d = 1'b1;
                end else begin
                    cnt_d   = cnt_dec;
                end
            end
            COOL_DOWN: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                    done_d  = clean_q;
                end else begin
                    cnt_d   = cnt_dec;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_int  = state_q;
    assign heater_en  = (state_q == WARMUP) || (state_q == TOAST);
    assign lever_lock = (state_q != IDLE);
    assign done       = done_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_toaster_seq_ctrl.sv
// Bench for toaster_seq_ctrl: directed scenarios plus random stimulus, scored against a phase/elapsed-time model.
module tb_toaster_seq_ctrl;

    localparam int WARMUP_MAX  = 100;
    localparam int TOAST_UNIT  = 16;
    localparam int COOL_CYCLES = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cancel = 1'b0;
    logic [2:0] darkness = 3'd0;
    logic       temp_ok = 1'b0;
    logic [1:0] state_int;
    logic       heater_en;
    logic       lever_lock;
    logic       done;
    logic       fault;

    toaster_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cancel    (cancel),
        .darkness  (darkness),
        .temp_ok   (temp_ok),
        .state_int (state_int),
        .heater_en (heater_en),
        .lever_lock(lever_lock),
        .done      (done),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // expected {state, heater, lock, done, fault} after each rising edge
    logic [5:0] exp_q[$];
    logic [5:0] mon_exp;
    logic [5:0] mon_got;

    // phase: 0 idle, 1 warmup, 2 toast, 3 cool; elapsed counts cycles already spent in phase
    int m_phase, m_el, m_dark;
    bit m_fault, m_clean, m_done;

    task model_reset();
        m_phase = 0; m_el = 0; m_dark = 0;
        m_fault = 0; m_clean = 0; m_done = 0;
    endtask

    task model_update(input bit s, input bit c, input int d, input bit t);
        m_done = 0;
        case (m_phase)
            0: if (s && d != 0) begin
                   m_phase = 1; m_el = 0; m_dark = d; m_fault = 0; m_clean = 0;
               end
            1: if (c) begin
                   m_phase = 3; m_el = 0;
               end else if (t) begin
                   m_phase = 2; m_el = 0;
               end else if (m_el == WARMUP_MAX - 1) begin
                   m_phase = 3; m_el = 0; m_fault = 1;
               end else m_el++;
            2: if (c) begin
                   m_phase = 3; m_el = 0;
               end else if (m_el == m_dark * TOAST_UNIT - 1) begin
                   m_phase = 3; m_el = 0; m_clean = 1;
               end else m_el++;
            default: if (m_el == COOL_CYCLES - 1) begin
                   m_phase = 0; m_el = 0; m_done = m_clean;
               end else m_el++;
        endcase
    endtask

    task step(input bit s, input bit c, input int d, input bit t);
        logic [1:0] ph;
        @(negedge clk);
        start = s; cancel = c; darkness = 3'(d); temp_ok = t;
        model_update(s, c, d, t);
        ph = 2'(m_phase);
        exp_q.push_back({ph, (m_phase == 1 || m_phase == 2), (m_phase != 0), m_done, m_fault});
    endtask

    task run(input bit s, input bit c, input int d, input bit t, input int n);
        for (int i = 0; i < n; i++) step(s, c, d, t);
    endtask

    task check_reset_now(input string name);
        checks++;
        if ({state_int, heater_en, lever_lock, done, fault} !== 6'b0) begin
            errors++;
            $display("FAIL %s: got state=%b heater=%b lock=%b done=%b fault=%b, want all zero",
                     name, state_int, heater_en, lever_lock, done, fault);
        end
    endtask

    // mid-cycle asynchronous reset from whatever state the DUT is in
    task async_reset(input string name);
        @(negedge clk);
        start = 0; cancel = 0; temp_ok = 0; darkness = 3'd0;
        #2 rst_n = 1'b0;
        #1 check_reset_now(name);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (rst_n && exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {state_int, heater_en, lever_lock, done, fault};
            checks++;
            if (mon_got !== mon_exp) begin
                errors++;
                $display("FAIL outputs @%0t: got state=%b heat=%b lock=%b done=%b fault=%b, want state=%b heat=%b lock=%b done=%b fault=%b",
                         $time, mon_got[5:4], mon_got[3], mon_got[2], mon_got[1], mon_got[0],
                         mon_exp[5:4], mon_exp[3], mon_exp[2], mon_exp[1], mon_exp[0]);
            end
        end
    end

    initial begin
        bit s, c, t;
        int d, tprob, cprob;
        model_reset();
        #3 check_reset_now("power_on_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // reset while toasting
        step(1, 0, 3, 0);
        step(0, 0, 3, 1);
        run(0, 0, 3, 0, 6);
        async_reset("reset_mid_toast");
        run(0, 0, 3, 0, 4);

        // normal run: temp_ok on the 10th warmup cycle
        step(1, 0, 3, 0);
        run(0, 0, 3, 0, 9);
        step(0, 0, 3, 1);
        run(0, 0, 7, 0, 48 + 32 + 3);

        // warmup timeout, fault held until next accepted start
        step(1, 0, 5, 0);
        run(0, 0, 5, 0, 100 + 32 + 5);
        step(1, 0, 2, 0);
        step(0, 0, 2, 1);
        run(0, 0, 2, 0, 32 + 32 + 2);

        // cancel at toast cycle 20, start pulse inside cool down
        step(1, 0, 4, 0);
        step(0, 0, 4, 1);
        run(0, 0, 4, 0, 19);
        step(0, 1, 4, 0);
        run(0, 0, 4, 0, 10);
        step(1, 0, 4, 0);
        run(0, 0, 4, 0, 25);

        // darkness 0 start is ignored, then darkness 1
        run(1, 0, 0, 0, 5);
        step(1, 0, 1, 0);
        step(0, 0, 1, 1);
        run(0, 0, 1, 0, 16 + 32 + 2);

        // cancel beats temp_ok; temp_ok on last warmup cycle beats timeout
        step(1, 0, 6, 0);
        run(0, 0, 6, 0, 3);
        step(0, 1, 6, 1);
        run(0, 0, 6, 0, 34);
        step(1, 0, 1, 0);
        run(0, 0, 1, 0, WARMUP_MAX - 1);
        step(0, 0, 1, 1);
        run(0, 0, 1, 0, 16 + 32 + 2);

        // start held through completion relaunches immediately
        step(1, 0, 1, 0);
        step(1, 0, 1, 1);
        run(1, 0, 1, 0, 16 + 32 + 3);
        run(0, 0, 0, 0, 130);

        tprob = 5; cprob = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                case ($urandom_range(0, 3))
                    0: tprob = 0;
                    1: tprob = 1;
                    2: tprob = 5;
                    default: tprob = 30;
                endcase
                case ($urandom_range(0, 2))
                    0: cprob = 0;
                    1: cprob = 5;
                    default: cprob = 20;
                endcase
            end
            s = ($urandom_range(0, 99) < 30);
            c = ($urandom_range(0, 999) < cprob);
            t = ($urandom_range(0, 99) < tprob);
            d = $urandom_range(0, 7);
            step(s, c, d, t);
            if (i == 1700) async_reset("reset_random");
        end

        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
